// File: rtl/nsa_pkg.sv
// nsa_pkg: shared types and constants for the nibble serial adder.
//   NIBBLE_W     - operand nibble width
//   IDX_W        - width of the per-operand beat index
//   state_t      - operand sequencing state (IDLE, RUN)
//   fifo_entry_t - one buffered result beat {sum, last, cout, idx}
//   sat_inc()    - saturating increment for the beat index
package nsa_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned IDX_W    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [NIBBLE_W-1:0] sum;
        logic                last;
        logic                cout;
        logic [IDX_W-1:0]    idx;
    } fifo_entry_t;

    function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/four_bit_parallel_adder.sv
// four_bit_parallel_adder: combinational ripple-carry adder for one nibble.
//   a, b  - operand nibbles
//   cin   - carry in
//   sum   - sum nibble
//   cout  - carry out of the most significant bit
module four_bit_parallel_adder
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < NIBBLE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two operands streamed least-significant nibble
// first, one nibble pair per accepted beat, and buffers each result nibble in
// a small FIFO.
//   FIFO_DEPTH            - result buffer entries (power of two, >= 2)
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - input handshake (in_ready = buffer not full)
//   in_a, in_b            - operand nibbles
//   in_first, in_last     - operand framing
//   in_sub                - only with NIBBLE_SERIAL_ADDER_SUB_EN defined:
//                           sampled on first beats, selects a-b
//   out_valid/out_ready   - output handshake
//   out_sum, out_last     - result nibble and its framing
//   out_cout              - carry out of the final nibble (0 on other beats)
//   out_idx               - beat index within the operand, saturating at 15
//   err                   - sticky protocol error (framing violations)
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NIBBLE_W-1:0] in_a,
    input  logic [NIBBLE_W-1:0] in_b,
    input  logic                in_first,
    input  logic                in_last,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic                in_sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NIBBLE_W-1:0] out_sum,
    output logic                out_last,
    output logic                out_cout,
    output logic [IDX_W-1:0]    out_idx,
    output logic                err
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    state_t              state;
    logic                carry;
    logic [IDX_W-1:0]    beat_cnt;

    fifo_entry_t         mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;

    logic                accept;
    logic                pop;
    logic                is_first;
    logic                proto_err;
    logic                sub_op;
    logic                add_cin;
    logic                add_cout;
    logic [NIBBLE_W-1:0] add_b;
    logic [NIBBLE_W-1:0] add_sum;
    logic [IDX_W-1:0]    beat_idx;
    fifo_entry_t         new_entry;
    fifo_entry_t         head;

    assign in_ready  = (count != (AW + 1)'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic sub_q;

    // Operation is latched on the first beat and reused for the rest.
    assign sub_op = is_first ? in_sub : sub_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (accept && is_first) begin
            sub_q <= in_sub;
        end
    end
`else
    assign sub_op = 1'b0;
`endif

    always_comb begin
        // A beat in IDLE starts an operand even if in_first is missing.
        is_first       = in_first | (state == IDLE);
        proto_err      = (state == IDLE) ? ~in_first : in_first;
        add_b          = in_b ^ {NIBBLE_W{sub_op}};
        add_cin        = is_first ? sub_op : carry;
        beat_idx       = is_first ? '0 : beat_cnt;
        new_entry.sum  = add_sum;
        new_entry.last = in_last;
        new_entry.cout = in_last & add_cout;
        new_entry.idx  = beat_idx;
    end

    four_bit_parallel_adder u_adder (
        .a    (in_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            carry    <= 1'b0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            state    <= in_last ? IDLE : RUN;
            carry    <= in_last ? 1'b0 : add_cout;
            beat_cnt <= in_last ? '0 : sat_inc(beat_idx);
            if (proto_err) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head     = mem[rd_ptr];
    assign out_sum  = out_valid ? head.sum  : '0;
    assign out_last = out_valid ? head.last : 1'b0;
    assign out_cout = out_valid ? head.cout : 1'b0;
    assign out_idx  = out_valid ? head.idx  : '0;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: randomized and directed bench for nibble_serial_adder.
// The reference model keeps each operand as a wide integer and derives every
// result nibble, carry and index from plain addition of the whole operands.
// Define NIBBLE_SERIAL_ADDER_SUB_EN for both bench and RTL to cover subtract.
module tb_nibble_serial_adder;

    localparam int unsigned DEPTH = 2;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    localparam bit SUB_ON = 1'b1;
    logic in_sub = 1'b0;
`else
    localparam bit SUB_ON = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [3:0] in_a = '0, in_b = '0;
    logic       in_ready, out_valid, out_last, out_cout, err;
    logic [3:0] out_sum, out_idx;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] sum;
        logic       last;
        logic       cout;
        logic [3:0] idx;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        act_q[$];
    int unsigned  m_occ = 0;
    logic         m_in_op = 1'b0, m_err = 1'b0, m_sub = 1'b0;
    logic [135:0] m_a, m_b;
    int unsigned  m_k = 0;
    int unsigned  viol = 0;
    string        viol_msg = "";
    logic         hold_pending = 1'b0;
    beat_t        held;
    int unsigned  accepted_cnt = 0;

    nibble_serial_adder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_idx   (out_idx),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Whole-operand arithmetic: nibble k of (A + B + cin) over the beats so far.
    task automatic model_accept(input logic [3:0] a, input logic [3:0] b,
                                input logic f, input logic l, input logic sub);
        beat_t        e;
        logic [135:0] total;
        logic [3:0]   bn;
        if (f == m_in_op) m_err = 1'b1;
        if (f || !m_in_op) begin
            m_a = '0; m_b = '0; m_k = 0; m_sub = sub;
        end
        bn    = m_sub ? ~b : b;
        m_a   = m_a | (136'(a) << (4 * m_k));
        m_b   = m_b | (136'(bn) << (4 * m_k));
        total = m_a + m_b + 136'(m_sub);
        e.sum  = 4'(total >> (4 * m_k));
        e.last = l;
        e.cout = l ? total[4 * m_k + 4] : 1'b0;
        e.idx  = (m_k > 15) ? 4'd15 : 4'(m_k);
        exp_q.push_back(e);
        m_in_op = !l;
        m_k++;
    endtask

    // One clock of stimulus; records popped beats and handshake deviations.
    task automatic drive_cycle(input logic v, input logic [3:0] a, input logic [3:0] b,
                               input logic f, input logic l, input logic rdy, input logic sub);
        beat_t obs;
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_first = f; in_last = l; out_ready = rdy;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        in_sub = sub;
`endif
        #1;
        obs = {out_sum, out_last, out_cout, out_idx};
        if (out_valid !== (m_occ != 0)) begin
            if (viol == 0) viol_msg = $sformatf("out_valid=%b occupancy=%0d", out_valid, m_occ);
            viol++;
        end
        if (in_ready !== (m_occ < DEPTH)) begin
            if (viol == 0) viol_msg = $sformatf("in_ready=%b occupancy=%0d", in_ready, m_occ);
            viol++;
        end
        if (err !== m_err) begin
            if (viol == 0) viol_msg = $sformatf("err=%b required %b", err, m_err);
            viol++;
        end
        if (hold_pending && (out_valid !== 1'b1 || obs !== held)) begin
            if (viol == 0) viol_msg = $sformatf("stalled output %h required %h", obs, held);
            viol++;
        end
        hold_pending = (out_valid === 1'b1) && !rdy;
        held = obs;
        if (out_valid === 1'b1 && rdy) begin
            act_q.push_back(obs);
            if (m_occ > 0) m_occ--;
        end
        if (v && in_ready === 1'b1) begin
            model_accept(a, b, f, l, sub & SUB_ON);
            m_occ++;
            accepted_cnt++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && m_occ != 0; i++) drive_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (m_occ != 0) begin
            if (viol == 0) viol_msg = $sformatf("drain timeout occupancy=%0d", m_occ);
            viol++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        exp_q.delete(); act_q.delete();
        m_occ = 0; m_in_op = 1'b0; m_err = 1'b0; hold_pending = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_sum, out_last, out_cout, out_idx, err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 000",
                     {out_valid, out_sum, out_last, out_cout, out_idx, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_single_beat();
        beat_t e, o;
        drive_cycle(1'b1, 4'h9, 4'h8, 1'b1, 1'b1, 1'b1, 1'b0);
        drain();
        checks++;
        if (act_q.size() != 1 || act_q[0] !== {4'h1, 1'b1, 1'b1, 4'h0}) begin
            errors++; $display("FAIL single_beat: got %0d beats first=%h required 1 beat 1c0", act_q.size(),
                               act_q.size() ? act_q[0] : beat_t'('0));
        end
        while (exp_q.size() && act_q.size()) begin
            e = exp_q.pop_front(); o = act_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL single_beat_model: got %h required %h", o, e); end
        end
        checks++;
        if (viol != 0 || err !== 1'b0) begin
            errors++; $display("FAIL single_beat_handshake: violations=%0d err=%b required 0 (%s)", viol, err, viol_msg);
        end
        viol = 0;
    endtask

    task automatic test_two_beats();
        beat_t e, o;
        drive_cycle(1'b1, 4'hF, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        checks++;
        if (act_q.size() != 2 || act_q[0] !== {4'h0, 1'b0, 1'b0, 4'h0} || act_q[1] !== {4'h1, 1'b1, 1'b0, 4'h1}) begin
            errors++; $display("FAIL two_beats: got %0d beats required 000,141", act_q.size());
        end
        while (exp_q.size() && act_q.size()) begin
            e = exp_q.pop_front(); o = act_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL two_beats_model: got %h required %h", o, e); end
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL two_beats_handshake: violations=%0d required 0 (%s)", viol, viol_msg); end
        viol = 0;
    endtask

    task automatic test_backpressure();
        beat_t       e, o;
        logic [3:0]  va[3];
        int unsigned i = 0, base;
        va[0] = 4'h7; va[1] = 4'hA; va[2] = 4'h3;
        base = accepted_cnt;
        for (int c = 0; c < 5; c++) begin
            drive_cycle(i < 3, va[i % 3], 4'h9, i == 0, i == 2, 1'b0, 1'b0);
            if (accepted_cnt - base > i) i++;
        end
        checks++;
        if (accepted_cnt - base != 2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL backpressure_full: accepted=%0d in_ready=%b required 2,0", accepted_cnt - base, in_ready);
        end
        for (int c = 0; c < 20 && i < 3; c++) begin
            drive_cycle(1'b1, va[i], 4'h9, i == 0, i == 2, 1'b1, 1'b0);
            if (accepted_cnt - base > i) i++;
        end
        drain();
        checks++;
        if (act_q.size() != 3) begin errors++; $display("FAIL backpressure_count: got %0d required 3", act_q.size()); end
        while (exp_q.size() && act_q.size()) begin
            e = exp_q.pop_front(); o = act_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL backpressure_model: got %h required %h", o, e); end
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL backpressure_handshake: violations=%0d required 0 (%s)", viol, viol_msg); end
        viol = 0;
    endtask

    task automatic test_protocol();
        beat_t e, o;
        drive_cycle(1'b1, 4'h3, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 4'h5, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 4'h7, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b1, 4'h2, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        checks++;
        if (act_q.size() != 4 || act_q[1] !== {4'hB, 1'b0, 1'b0, 4'h0} || act_q[3] !== {4'h4, 1'b1, 1'b0, 4'h0}) begin
            errors++; $display("FAIL protocol_restart: got %0d beats required restart beat b00 and idle beat 440", act_q.size());
        end
        while (exp_q.size() && act_q.size()) begin
            e = exp_q.pop_front(); o = act_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL protocol_model: got %h required %h", o, e); end
        end
        repeat (5) drive_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL protocol_err_sticky: got %b required 1", err); end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL protocol_handshake: violations=%0d required 0 (%s)", viol, viol_msg); end
        viol = 0;
    endtask

    task automatic test_reset_mid();
        beat_t e, o;
        apply_reset();
        drive_cycle(1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL reset_mid_flush: out_valid=%b in_ready=%b err=%b required 0,1,0", out_valid, in_ready, err);
        end
        drive_cycle(1'b1, 4'h1, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0);
        drain();
        checks++;
        if (act_q.size() != 1 || act_q[0] !== {4'h2, 1'b1, 1'b0, 4'h0}) begin
            errors++; $display("FAIL reset_mid_carry: got %0d beats required one beat 240", act_q.size());
        end
        while (exp_q.size() && act_q.size()) begin
            e = exp_q.pop_front(); o = act_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_mid_model: got %h required %h", o, e); end
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL reset_mid_handshake: violations=%0d required 0 (%s)", viol, viol_msg); end
        viol = 0;
    endtask

    task automatic test_saturation();
        beat_t e, o;
        for (int i = 0; i < 20; i++)
            drive_cycle(1'b1, 4'($urandom), 4'($urandom), i == 0, i == 19, 1'b1, 1'b0);
        drain();
        checks++;
        if (act_q.size() != 20 || act_q[14].idx !== 4'd14 || act_q[15].idx !== 4'd15 || act_q[19].idx !== 4'd15) begin
            errors++; $display("FAIL saturation_idx: got %0d beats required idx 14,15,15 at beats 14,15,19", act_q.size());
        end
        while (exp_q.size() && act_q.size()) begin
            e = exp_q.pop_front(); o = act_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL saturation_model: got %h required %h", o, e); end
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL saturation_handshake: violations=%0d required 0 (%s)", viol, viol_msg); end
        viol = 0;
    endtask

    task automatic test_sub();
        beat_t e, o;
        drive_cycle(1'b1, 4'h0, 4'h1, 1'b1, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b1, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        checks++;
        if (act_q.size() != 2 || act_q[0] !== {4'hF, 1'b0, 1'b0, 4'h0} || act_q[1] !== {4'h0, 1'b1, 1'b1, 4'h1}) begin
            errors++; $display("FAIL sub_borrow: got %0d beats required f00,0c1", act_q.size());
        end
        while (exp_q.size() && act_q.size()) begin
            e = exp_q.pop_front(); o = act_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sub_model: got %h required %h", o, e); end
        end
        viol = 0;
    endtask

    task automatic test_random();
        beat_t       e, o;
        int unsigned left = 0, base;
        logic        v, f, l, s;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if (left == 0) left = $urandom_range(1, 6);
            v = ($urandom_range(0, 3) != 0);
            f = (left == 0) || (m_k == 0) || !m_in_op;
            if ($urandom_range(0, 19) == 0) f = !f;
            l = (left == 1);
            s = 1'($urandom);
            base = accepted_cnt;
            drive_cycle(v, 4'($urandom), 4'($urandom), f, l, $urandom_range(0, 9) < 7, s);
            if (accepted_cnt != base) left--;
        end
        drain();
        checks++;
        if (exp_q.size() != act_q.size()) begin
            errors++; $display("FAIL random_count: got %0d beats required %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() && act_q.size()) begin
            e = exp_q.pop_front(); o = act_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL random_model: got %h required %h", o, e); end
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL random_handshake: violations=%0d required 0 (%s)", viol, viol_msg); end
        viol = 0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_two_beats();
        test_backpressure();
        test_protocol();
        test_reset_mid();
        test_saturation();
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
